// File: rtl/decode_stage_pkg.sv
// Shared instruction types and decode helpers for the decode/operand-fetch stage.
// Encodings follow the RV32I base opcode map.
package decode_stage_pkg;

   typedef logic [31:0] instruction_t;
   typedef logic [31:0] register_t;
   typedef logic [4:0]  register_num_t;

   localparam instruction_t EBREAK = 32'h0010_0073;

   localparam logic [6:0] OpcLoad   = 7'b0000011;
   localparam logic [6:0] OpcOpImm  = 7'b0010011;
   localparam logic [6:0] OpcAuipc  = 7'b0010111;
   localparam logic [6:0] OpcStore  = 7'b0100011;
   localparam logic [6:0] OpcOp     = 7'b0110011;
   localparam logic [6:0] OpcLui    = 7'b0110111;
   localparam logic [6:0] OpcBranch = 7'b1100011;
   localparam logic [6:0] OpcJalr   = 7'b1100111;
   localparam logic [6:0] OpcJal    = 7'b1101111;

   typedef enum logic [3:0] {
      InstrR,
      InstrI,
      InstrShiftI,
      InstrS,
      InstrB,
      InstrU,
      InstrJ,
      InstrEbreak,
      InstrIllegal
   } instr_type_e;

   function automatic instr_type_e get_type(instruction_t i);
      instr_type_e t;
      if (i == EBREAK) begin
         t = InstrEbreak;
      end else begin
         case (i[6:0])
            OpcOp:              t = InstrR;
            // funct3 001 (SLLI) and 101 (SRLI/SRAI) are the only codes with [13:12] == 01
            OpcOpImm:           t = (i[13:12] == 2'b01) ? InstrShiftI : InstrI;
            OpcLoad, OpcJalr:   t = InstrI;
            OpcStore:           t = InstrS;
            OpcBranch:          t = InstrB;
            OpcLui, OpcAuipc:   t = InstrU;
            OpcJal:             t = InstrJ;
            default:            t = InstrIllegal;
         endcase
      end
      return t;
   endfunction

   function automatic logic is_r_type(instruction_t i);
      return get_type(i) == InstrR;
   endfunction

   function automatic logic is_illegal_type(instruction_t i);
      return get_type(i) == InstrIllegal;
   endfunction

   function automatic register_num_t get_rs1(instruction_t i);
      return i[19:15];
   endfunction

   function automatic register_num_t get_rs2(instruction_t i);
      return i[24:20];
   endfunction

   function automatic register_num_t get_rd(instruction_t i);
      return i[11:7];
   endfunction

   function automatic register_t get_imm(instruction_t i, instr_type_e t);
      register_t imm;
      case (t)
         InstrI:      imm = {{20{i[31]}}, i[31:20]};
         InstrShiftI: imm = {27'b0, i[24:20]};
         InstrS:      imm = {{20{i[31]}}, i[31:25], i[11:7]};
         InstrB:      imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         InstrU:      imm = {i[31:12], 12'b0};
         InstrJ:      imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         default:     imm = '0;
      endcase
      return imm;
   endfunction

   // Types that retire a value into rd and therefore reserve it in the scoreboard.
   function automatic logic is_writer(instr_type_e t);
      return t inside {InstrR, InstrI, InstrShiftI, InstrU, InstrJ};
   endfunction

   function automatic logic uses_rs1(instr_type_e t);
      return t inside {InstrR, InstrI, InstrShiftI, InstrS, InstrB};
   endfunction

   function automatic logic uses_rs2(instr_type_e t);
      return t inside {InstrR, InstrS, InstrB};
   endfunction

endpackage

// File: rtl/decode_stage_scoreboard.sv
// Register busy tracker: reserves rd on issue, releases on writeback, clears on flush.
// Issue beats writeback when both name the same register in one cycle.
module decode_stage_scoreboard
   import decode_stage_pkg::*;
#(
   parameter int unsigned NREGS = 32,
   localparam int unsigned RW = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          set_valid,
   input  logic [RW-1:0] set_rd,
   input  logic          clr_valid,
   input  logic [RW-1:0] clr_rd,
   input  logic [RW-1:0] rs1,
   input  logic [RW-1:0] rs2,
   output logic          rs1_busy,
   output logic          rs2_busy
);

   logic [NREGS-1:0] busy_q, busy_d;

   always_comb begin
      busy_d = busy_q;
      if (clr_valid) begin
         busy_d[clr_rd] = 1'b0;
      end
      if (set_valid) begin
         busy_d[set_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
      if (flush) begin
         busy_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign rs1_busy = busy_q[rs1];
   assign rs2_busy = busy_q[rs2];

endmodule

// File: rtl/decode_stage.sv
// Elastic decode/operand-fetch stage: decodes, resolves operands through forwarding or the
// register file, stalls on unresolved RAW hazards and registers the bundle for execute.
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter int unsigned XLEN          = 32,
   parameter int unsigned NREGS         = 32,
   parameter int unsigned NFWD          = 2,
   parameter bit          SB_EN         = 1'b1,
   parameter bit          RANDOM_ERRORS = 1'b0,
   localparam int unsigned RW = $clog2(NREGS)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  instruction_t                     instr,
   input  logic [NREGS-1:0][XLEN-1:0]       register_bank,
   input  logic [NFWD-1:0]                  fwd_valid,
   input  logic [NFWD-1:0][RW-1:0]          fwd_rd,
   input  logic [NFWD-1:0][XLEN-1:0]        fwd_data,
   input  logic                             wb_valid,
   input  logic [RW-1:0]                    wb_rd,
   input  logic                             flush,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [XLEN-1:0]                  op1,
   output logic [XLEN-1:0]                  op2,
   output logic [XLEN-1:0]                  op3,
   output logic [RW-1:0]                    rd,
   output instruction_t                     instr_out,
   output logic                             illegal
);

   typedef struct packed {
      logic            valid;
      logic [RW-1:0]   rd;
      logic [XLEN-1:0] data;
   } fwd_chan_t;

   typedef struct packed {
      logic [XLEN-1:0] op1;
      logic [XLEN-1:0] op2;
      logic [XLEN-1:0] op3;
      logic [RW-1:0]   rd;
      instruction_t    instr;
      logic            illegal;
   } decode_bundle_t;

   fwd_chan_t [NFWD-1:0] fwd;
   instr_type_e          itype;
   logic [XLEN-1:0]      imm;
   logic [RW-1:0]        src_idx [2];
   logic [XLEN-1:0]      src_val [2];
   logic                 src_fwd [2];
   logic [1:0]           rs_busy;
   logic                 stall;
   logic                 accept;
   decode_bundle_t       bundle_d, bundle_q;
   logic                 out_valid_q;

   always_comb begin
      fwd = '0;
      for (int c = 0; c < int'(NFWD); c++) begin
         fwd[c].valid = fwd_valid[c];
         fwd[c].rd    = fwd_rd[c];
         fwd[c].data  = fwd_data[c];
      end
   end

   assign itype      = get_type(instr);
   assign imm        = XLEN'($signed(get_imm(instr, itype)));
   assign src_idx[0] = RW'(get_rs1(instr));
   assign src_idx[1] = RW'(get_rs2(instr));

   // Walk channels oldest-to-youngest so the lowest index is applied last and wins.
   always_comb begin
      for (int s = 0; s < 2; s++) begin
         src_fwd[s] = 1'b0;
         src_val[s] = register_bank[src_idx[s]];
         for (int c = int'(NFWD) - 1; c >= 0; c--) begin
            if (fwd[c].valid && (fwd[c].rd != '0) && (fwd[c].rd == src_idx[s])) begin
               src_fwd[s] = 1'b1;
               src_val[s] = fwd[c].data;
            end
         end
         if (src_idx[s] == '0) begin
            src_fwd[s] = 1'b0;
            src_val[s] = '0;
         end
      end
   end

   always_comb begin
      bundle_d       = '0;
      bundle_d.instr = instr;
      unique case (itype)
         InstrR: begin
            bundle_d.op1 = src_val[0];
            bundle_d.op2 = src_val[1];
            bundle_d.rd  = RW'(get_rd(instr));
         end
         InstrI, InstrShiftI: begin
            bundle_d.op1 = src_val[0];
            bundle_d.op2 = imm;
            bundle_d.rd  = RW'(get_rd(instr));
         end
         InstrS: begin
            bundle_d.op1 = src_val[0];
            bundle_d.op2 = imm;
            bundle_d.op3 = src_val[1];
         end
         InstrB: begin
            bundle_d.op1 = src_val[0];
            bundle_d.op2 = src_val[1];
            bundle_d.op3 = imm;
         end
         InstrU, InstrJ: begin
            bundle_d.op1 = imm;
            bundle_d.rd  = RW'(get_rd(instr));
         end
         InstrEbreak: begin
         end
         default: begin
            bundle_d.illegal = 1'b1;
         end
      endcase
   end

   // A forward on the same cycle resolves the hazard, so only unforwarded busy sources stall.
   assign stall = SB_EN && in_valid &&
                  ((uses_rs1(itype) && rs_busy[0] && !src_fwd[0]) ||
                   (uses_rs2(itype) && rs_busy[1] && !src_fwd[1]));

   assign in_ready = !flush && !stall && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   if (SB_EN) begin : g_sb
      decode_stage_scoreboard #(
         .NREGS (NREGS)
      ) u_scoreboard (
         .clk       (clk),
         .rst_n     (rst_n),
         .flush     (flush),
         .set_valid (accept && is_writer(itype)),
         .set_rd    (bundle_d.rd),
         .clr_valid (wb_valid),
         .clr_rd    (wb_rd),
         .rs1       (src_idx[0]),
         .rs2       (src_idx[1]),
         .rs1_busy  (rs_busy[0]),
         .rs2_busy  (rs_busy[1])
      );
   end else begin : g_no_sb
      assign rs_busy = '0;
   end

`ifndef SYNTHESIS
   function automatic decode_bundle_t inject_error(decode_bundle_t b);
      decode_bundle_t r;
      r = b;
      case ($urandom_range(3))
         0:       r.op1 = r.op1 ^ (XLEN'(1) << $urandom_range(XLEN - 1));
         1:       r.op2 = r.op2 ^ (XLEN'(1) << $urandom_range(XLEN - 1));
         2:       r.op3 = r.op3 ^ (XLEN'(1) << $urandom_range(XLEN - 1));
         default: r.rd  = r.rd ^ (RW'(1) << $urandom_range(RW - 1));
      endcase
      return r;
   endfunction
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         bundle_q    <= '0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         bundle_q    <= bundle_d;
`ifndef SYNTHESIS
         if (RANDOM_ERRORS && ($urandom_range(9) == 0)) begin
            bundle_q <= inject_error(bundle_d);
         end
`endif
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid = out_valid_q;
   assign op1       = bundle_q.op1;
   assign op2       = bundle_q.op2;
   assign op3       = bundle_q.op3;
   assign rd        = bundle_q.rd;
   assign instr_out = bundle_q.instr;
   assign illegal   = bundle_q.illegal;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Parametrised successor to the single-cycle decoder: an elastic decode/operand-fetch pipeline stage with valid/ready handshakes on both sides.
- Adds a register scoreboard with RAW-hazard stall, NFWD result-forwarding channels, flush, and illegal-instruction flagging.
- Sits between fetch and execute; operands are captured at accept time, so outputs stay stable under back-pressure.

Parameters:
- XLEN, 32, register/operand width.
- NREGS, 32, architectural register count; register index width RW = $clog2(NREGS).
- NFWD, 2, number of forwarding channels (index 0 = youngest stage, highest priority).
- SB_EN, 1, 1 = scoreboard stall active; 0 = no stall, forwarding only.
- RANDOM_ERRORS, 0, simulation-only: 1-in-10 single-bit flip on op1/op2/op3/rd at capture; compiled out under SYNTHESIS.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction valid from fetch.
- in_ready  out  1  stage accepts this cycle.
- instr  in  32  instruction (instruction_t).
- register_bank  in  NREGS x XLEN  architectural register file read view.
- fwd_valid  in  NFWD  forwarding channel valid.
- fwd_rd  in  NFWD x RW  forwarding destination register.
- fwd_data  in  NFWD x XLEN  forwarding value.
- wb_valid  in  1  writeback retires a register.
- wb_rd  in  RW  retired register.
- flush  in  1  synchronous pipeline flush.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts.
- op1, op2, op3  out  XLEN each  operands.
- rd  out  RW  destination register.
- instr_out  out  32  accepted instruction.
- illegal  out  1  accepted instruction is not a recognised type.

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid, op1, op2, op3, rd, instr_out, illegal and all scoreboard bits = 0.
- Handshake:
  - accept = in_valid & in_ready.
  - in_ready = !flush & !stall & (!out_valid | out_ready).
  - Output register loads on accept, giving 1-cycle latency.
  - If out_ready & !accept, out_valid drops to 0.
  - If out_valid & !out_ready, all outputs are held bit-stable.
- Source operand value:
  - x0 always reads 0.
  - Otherwise the lowest-index channel with fwd_valid=1 and fwd_rd = source supplies the value.
  - Otherwise the value is read from register_bank.
  - fwd_rd = 0 is ignored.
- Operand mapping per instruction type:
  - R: op1=rs1, op2=rs2, op3=0.
  - I/shift-I: op1=rs1, op2=imm.
  - S: op1=rs1, op2=imm, op3=rs2.
  - B: op1=rs1, op2=rs2, op3=imm.
  - U/J: op1=imm.
  - EBREAK: all operands 0, illegal=0.
  - Any other encoding: illegal=1, operands 0, rd 0.
- Scoreboard (SB_EN=1):
  - busy[NREGS] bit vector; busy[0] is hard-wired 0.
  - On accept of a register-writing type (R, I, shift-I, U, J) with rd≠0, set busy[rd].
  - wb_valid clears busy[wb_rd].
  - If set and clear hit the same register in the same cycle, set wins.
- Stall: in_valid and any used source register r has busy[r]=1 with no matching valid forward this cycle -> stall=1 and in_ready=0.
- Flush:
  - out_valid <= 0, busy <= 0, and no accept that cycle.
  - Flush takes priority over accept, wb and back-pressure.
- Reset asserted mid-transfer aborts immediately; there is no partial state.
- SB_EN=0: stall is tied to 0 and busy is unused.

Decomposition:
- opcodes package:
  - Existing: instruction_t, register_t, register_num_t, is_*_type/get_* helpers, EBREAK.
  - New: parameterised fwd_chan_t struct (valid, rd, data); an is_writer() helper; a decode_bundle_t struct for the output register.
- One sub-module: decode_scoreboard (busy vector, set/clear/flush, per-source busy query).

Test Plan:
- Reset then in_valid with ADDI x5,x0,7, out_ready=1 -> next cycle out_valid=1, op1=0, op2=7, rd=5, busy[5]=1; wb_valid, wb_rd=5 -> busy[5]=0.
- ADD x3,x1,x2 with bank x1=10, x2=20, fwd0=(1,x2,99), fwd1=(1,x2,55) -> op1=10, op2=99 (channel 0 wins).
- ADDI x4,x0,1 accepted, then ADD x6,x4,x4 with no forwarding -> in_ready=0 until wb_rd=4; alternatively fwd1=(1,x4,1) same cycle -> accepted, op1=op2=1.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> outputs bit-stable, in_ready=0, no second accept; out_ready=1 -> next instruction enters the following cycle.
- flush asserted while out_valid=1, busy[7]=1 and in_valid=1 -> next cycle out_valid=0, busy=0, instruction not accepted.
- instr=32'hFFFFFFFF -> illegal=1, rd=0, no busy bit set; EBREAK -> illegal=0, op1=0; wb_rd=9 and accept writing x9 in the same cycle -> busy[9]=1.
